// File: rtl/hazard_scoreboard.sv
// Decode-stage forwarding/stall unit: tracks in-flight register writes with per-write result
// latency, bypasses ready results to the source ports and stalls on results not yet produced.
module hazard_scoreboard #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NSRC   = 2,
    parameter int STAGES = 3,
    parameter int LAT_W  = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     hold,
    input  logic                     flush,
    input  logic                     issue_valid,
    input  logic                     issue_we,
    input  logic [ADDR_W-1:0]        issue_addr,
    input  logic [LAT_W-1:0]         issue_lat,
    input  logic [NSRC*ADDR_W-1:0]   src_addr,
    input  logic [NSRC-1:0]          src_used,
    input  logic [NSRC*DATA_W-1:0]   rf_data,
    input  logic [STAGES*DATA_W-1:0] stage_data,
    output logic [NSRC*DATA_W-1:0]   src_data,
    output logic [NSRC-1:0]          src_fwd,
    output logic                     stall,
    output logic [31:0]              stall_cycles
);

    localparam logic [LAT_W-1:0] LAT_MAX  = LAT_W'(STAGES - 1);
    localparam logic [LAT_W-1:0] LAT_ZERO = {LAT_W{1'b0}};
    localparam logic [31:0]      CNT_MAX  = 32'hFFFF_FFFF;

    logic [STAGES-1:0] valid_q, valid_d;
    logic [ADDR_W-1:0] addr_q [STAGES];
    logic [ADDR_W-1:0] addr_d [STAGES];
    logic [LAT_W-1:0]  rem_q  [STAGES];
    logic [LAT_W-1:0]  rem_d  [STAGES];
    logic [31:0]       cnt_q, cnt_d;
    logic [NSRC-1:0]   pend_s;

    // Per-port youngest-match search: forward ready results, flag pending ones.
    always_comb begin
        logic hit_s;
        src_data = rf_data;
        src_fwd  = {NSRC{1'b0}};
        pend_s   = {NSRC{1'b0}};
        hit_s    = 1'b0;
        for (int i = 0; i < NSRC; i++) begin
            hit_s = 1'b0;
            for (int s = 0; s < STAGES; s++) begin
                if (!hit_s && valid_q[s] &&
                    (addr_q[s] == src_addr[i*ADDR_W +: ADDR_W]) &&
                    (src_addr[i*ADDR_W +: ADDR_W] != {ADDR_W{1'b0}})) begin
                    hit_s = 1'b1;
                    if (rem_q[s] == LAT_ZERO) begin
                        src_data[i*DATA_W +: DATA_W] = stage_data[s*DATA_W +: DATA_W];
                        src_fwd[i] = 1'b1;
                    end else begin
                        pend_s[i] = src_used[i];
                    end
                end else begin
                    hit_s = hit_s;
                end
            end
        end
    end

    assign stall        = |pend_s;
    assign stall_cycles = cnt_q;

    // Next-state: flush beats everything, hold freezes, otherwise shift and load stage 0.
    always_comb begin
        valid_d = valid_q;
        addr_d  = addr_q;
        rem_d   = rem_q;
        if (flush) begin
            valid_d = {STAGES{1'b0}};
        end else if (!hold) begin
            for (int s = STAGES - 1; s > 0; s--) begin
                valid_d[s] = valid_q[s-1];
                addr_d[s]  = addr_q[s-1];
                rem_d[s]   = (rem_q[s-1] == LAT_ZERO) ? LAT_ZERO : rem_q[s-1] - LAT_W'(1);
            end
            valid_d[0] = issue_valid & ~stall & issue_we & (issue_addr != {ADDR_W{1'b0}});
            addr_d[0]  = issue_addr;
            rem_d[0]   = (issue_lat > LAT_MAX) ? LAT_MAX : issue_lat;
        end else begin
            valid_d = valid_q;
        end
    end

    // Saturating count of cycles in which decode was actually held back by a hazard.
    always_comb begin
        if (stall && !hold && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + 32'd1;
        end else begin
            cnt_d = cnt_q;
        end
    end

    // State registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= {STAGES{1'b0}};
            cnt_q   <= 32'd0;
            for (int s = 0; s < STAGES; s++) begin
                addr_q[s] <= {ADDR_W{1'b0}};
                rem_q[s]  <= LAT_ZERO;
            end
        end else begin
            valid_q <= valid_d;
            addr_q  <= addr_d;
            rem_q   <= rem_d;
            cnt_q   <= cnt_d;
        end
    end

    hazard_scoreboard_chk #(.LAT_W(LAT_W)) u_chk (
        .clk        (clk),
        .rst_n      (rst_n),
        .last_valid (valid_q[STAGES-1]),
        .last_rem   (rem_q[STAGES-1])
    );

endmodule

// Simulation checker: an entry about to write the register file must have its result ready.
module hazard_scoreboard_chk #(
    parameter int LAT_W = 2
) (
    input logic             clk,
    input logic             rst_n,
    input logic             last_valid,
    input logic [LAT_W-1:0] last_rem
);

    // Last-stage entries must carry rem == 0.
    always @(posedge clk) begin
        if (rst_n && last_valid) begin
            assert (last_rem == {LAT_W{1'b0}})
                else $error("hazard_scoreboard: last-stage entry with nonzero remaining latency");
        end
    end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard with an age-based reference model checked every cycle.
module tb_hazard_scoreboard;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int NS = 2;
    localparam int ST = 3;
    localparam int LW = 2;
    localparam logic [DW-1:0] RF0 = 32'hAAAA_0000;
    localparam logic [DW-1:0] RF1 = 32'hBBBB_0001;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              hold = 1'b0;
    logic              flush = 1'b0;
    logic              issue_valid = 1'b0;
    logic              issue_we = 1'b0;
    logic [AW-1:0]     issue_addr = '0;
    logic [LW-1:0]     issue_lat = '0;
    logic [NS*AW-1:0]  src_addr = '0;
    logic [NS-1:0]     src_used = '0;
    logic [NS*DW-1:0]  rf_data = {RF1, RF0};
    logic [ST*DW-1:0]  stage_data = {32'h0000_2222, 32'h0000_1111, 32'h0000_1234};
    logic [NS*DW-1:0]  src_data;
    logic [NS-1:0]     src_fwd;
    logic              stall;
    logic [31:0]       stall_cycles;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    hazard_scoreboard #(.DATA_W(DW), .ADDR_W(AW), .NSRC(NS), .STAGES(ST), .LAT_W(LW)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .hold         (hold),
        .flush        (flush),
        .issue_valid  (issue_valid),
        .issue_we     (issue_we),
        .issue_addr   (issue_addr),
        .issue_lat    (issue_lat),
        .src_addr     (src_addr),
        .src_used     (src_used),
        .rf_data      (rf_data),
        .stage_data   (stage_data),
        .src_data     (src_data),
        .src_fwd      (src_fwd),
        .stall        (stall),
        .stall_cycles (stall_cycles)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    endtask

    // Reference model: each in-flight write remembers its latency; its stage index is its age in EX.
    bit            m_valid [ST];
    logic [AW-1:0] m_addr  [ST];
    int            m_lat   [ST];
    logic [31:0]   m_cnt;

    function automatic void model_eval(output logic [NS*DW-1:0] e_data,
                                       output logic [NS-1:0] e_fwd, output logic e_stall);
        e_data  = rf_data;
        e_fwd   = '0;
        e_stall = 1'b0;
        for (int i = 0; i < NS; i++) begin
            int hit;
            logic [AW-1:0] a;
            hit = -1;
            a   = src_addr[i*AW +: AW];
            for (int s = ST - 1; s >= 0; s--)
                if (m_valid[s] && m_addr[s] == a && a != 0) hit = s;
            if (hit >= 0) begin
                if (hit >= m_lat[hit]) begin
                    e_fwd[i] = 1'b1;
                    e_data[i*DW +: DW] = stage_data[hit*DW +: DW];
                end else if (src_used[i]) begin
                    e_stall = 1'b1;
                end
            end
        end
    endfunction

    always @(posedge clk or negedge rst_n) begin
        logic [NS*DW-1:0] d;
        logic [NS-1:0] f;
        logic st;
        if (!rst_n) begin
            for (int s = 0; s < ST; s++) m_valid[s] = 1'b0;
            m_cnt = 32'd0;
        end else begin
            model_eval(d, f, st);
            if (st && !hold && m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 32'd1;
            if (flush) begin
                for (int s = 0; s < ST; s++) m_valid[s] = 1'b0;
            end else if (!hold) begin
                for (int s = ST - 1; s > 0; s--) begin
                    m_valid[s] = m_valid[s-1];
                    m_addr[s]  = m_addr[s-1];
                    m_lat[s]   = m_lat[s-1];
                end
                m_valid[0] = issue_valid && !st && issue_we && issue_addr != 0;
                m_addr[0]  = issue_addr;
                m_lat[0]   = (int'(issue_lat) > ST - 1) ? ST - 1 : int'(issue_lat);
            end
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        logic [NS*DW-1:0] d;
        logic [NS-1:0] f;
        logic st;
        model_eval(d, f, st);
        chk("stall", 64'(stall), 64'(st));
        chk("src_fwd", 64'(src_fwd), 64'(f));
        chk("src_data", src_data, d);
        chk("stall_cycles", 64'(stall_cycles), 64'(m_cnt));
    end

    task automatic mid();
        @(negedge clk);
        #1;
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic iss(input logic v, input logic we, input logic [AW-1:0] a, input logic [LW-1:0] l);
        issue_valid = v;
        issue_we    = we;
        issue_addr  = a;
        issue_lat   = l;
    endtask

    task automatic src(input logic [AW-1:0] a0, input logic u0, input logic [AW-1:0] a1, input logic u1);
        src_addr = {a1, a0};
        src_used = {u1, u0};
    endtask

    task automatic drain();
        iss(1'b0, 1'b0, 5'd0, 2'd0);
        src(5'd0, 1'b0, 5'd0, 1'b0);
        repeat (3) nxt();
    endtask

    initial begin
        nxt();
        nxt();
        rst_n = 1'b1;
        mid();
        chk("rst_stall", 64'(stall), 64'd0);
        chk("rst_fwd", 64'(src_fwd), 64'd0);
        chk("rst_data", src_data, {RF1, RF0});
        chk("rst_cnt", 64'(stall_cycles), 64'd0);
        nxt();

        // ALU chain
        iss(1'b1, 1'b1, 5'd8, 2'd0);
        nxt();
        iss(1'b0, 1'b0, 5'd0, 2'd0);
        src(5'd8, 1'b1, 5'd0, 1'b0);
        mid();
        chk("alu_data0", 64'(src_data[31:0]), 64'h1234);
        chk("alu_fwd", 64'(src_fwd), 64'd1);
        chk("alu_stall", 64'(stall), 64'd0);
        nxt();

        // Load-use
        iss(1'b1, 1'b1, 5'd9, 2'd1);
        src(5'd0, 1'b0, 5'd0, 1'b0);
        nxt();
        iss(1'b1, 1'b0, 5'd0, 2'd0);
        src(5'd0, 1'b0, 5'd9, 1'b1);
        mid();
        chk("load_stall", 64'(stall), 64'd1);
        chk("load_nofwd", 64'(src_fwd), 64'd0);
        nxt();
        mid();
        chk("load_stall2", 64'(stall), 64'd0);
        chk("load_data1", 64'(src_data[63:32]), 64'h1111);
        chk("load_fwd", 64'(src_fwd), 64'd2);
        chk("load_cnt", 64'(stall_cycles), 64'd1);
        nxt();
        drain();

        // MUL
        iss(1'b1, 1'b1, 5'd10, 2'd2);
        nxt();
        iss(1'b1, 1'b0, 5'd0, 2'd0);
        src(5'd10, 1'b1, 5'd0, 1'b0);
        mid();
        chk("mul_stall_a", 64'(stall), 64'd1);
        nxt();
        mid();
        chk("mul_stall_b", 64'(stall), 64'd1);
        nxt();
        mid();
        chk("mul_stall_c", 64'(stall), 64'd0);
        chk("mul_data0", 64'(src_data[31:0]), 64'h2222);
        chk("mul_fwd", 64'(src_fwd), 64'd1);
        chk("mul_cnt", 64'(stall_cycles), 64'd3);
        nxt();
        drain();

        // Youngest wins
        stage_data = {32'h0000_2222, 32'h0000_000A, 32'h0000_000B};
        iss(1'b1, 1'b1, 5'd5, 2'd0);
        nxt();
        iss(1'b1, 1'b1, 5'd5, 2'd0);
        nxt();
        iss(1'b0, 1'b0, 5'd0, 2'd0);
        src(5'd5, 1'b1, 5'd0, 1'b0);
        mid();
        chk("young_s0", 64'(src_data[31:0]), 64'hB);
        nxt();
        mid();
        chk("young_s1", 64'(src_data[31:0]), 64'hA);
        nxt();
        drain();

        // Masking: $0 source and unused port on a pending register
        iss(1'b1, 1'b1, 5'd12, 2'd2);
        nxt();
        iss(1'b1, 1'b0, 5'd0, 2'd0);
        src(5'd0, 1'b1, 5'd12, 1'b0);
        mid();
        chk("mask_stall", 64'(stall), 64'd0);
        chk("mask_fwd", 64'(src_fwd), 64'd0);
        chk("mask_data", src_data, {RF1, RF0});
        nxt();
        drain();

        // Hold then flush during a stall
        iss(1'b1, 1'b1, 5'd13, 2'd2);
        nxt();
        iss(1'b1, 1'b0, 5'd0, 2'd0);
        src(5'd13, 1'b1, 5'd0, 1'b0);
        hold = 1'b1;
        mid();
        chk("hold_stall_a", 64'(stall), 64'd1);
        chk("hold_cnt_a", 64'(stall_cycles), 64'd3);
        nxt();
        mid();
        chk("hold_stall_b", 64'(stall), 64'd1);
        chk("hold_cnt_b", 64'(stall_cycles), 64'd3);
        hold = 1'b0;
        nxt();
        flush = 1'b1;
        mid();
        chk("pre_flush_stall", 64'(stall), 64'd1);
        chk("pre_flush_cnt", 64'(stall_cycles), 64'd4);
        nxt();
        flush = 1'b0;
        mid();
        chk("flush_stall", 64'(stall), 64'd0);
        chk("flush_cnt", 64'(stall_cycles), 64'd5);
        nxt();

        // Reset in the middle of a stall
        iss(1'b1, 1'b1, 5'd14, 2'd2);
        src(5'd0, 1'b0, 5'd0, 1'b0);
        nxt();
        iss(1'b1, 1'b0, 5'd0, 2'd0);
        src(5'd14, 1'b1, 5'd0, 1'b0);
        mid();
        chk("prerst_stall", 64'(stall), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_stall", 64'(stall), 64'd0);
        chk("rst_mid_cnt", 64'(stall_cycles), 64'd0);
        nxt();
        rst_n = 1'b1;
        mid();
        chk("post_rst_stall", 64'(stall), 64'd0);
        nxt();
        nxt();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
